// File: rtl/serial_sub.sv
// serial_sub: digit-serial WIDTH-bit subtractor, d = x - y - bin.
// Processes DIGIT bits per clock, LSB first. The borrow between digits is held
// in a register. A new operation is accepted on start in IDLE or DONE.
// d/br/ovf are registered and hold their value until the next completion.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits per cycle (must divide WIDTH; DIGIT == WIDTH is single-cycle)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled in IDLE or DONE together with x, y, bin
//   x, y   minuend / subtrahend
//   bin    borrow-in
//   busy   high while the operation is running
//   done   one-cycle completion pulse (d/br/ovf valid from this cycle)
//   d      difference
//   br     borrow out of the MSB
//   ovf    two's-complement overflow
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             br,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] xs, ys, rs, rs_next, dig_ext;
    logic             b;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dig;
    logic             b_out;
    logic             b_msb_in;
    logic             bt;
    logic             last;
    logic             accept;

    assign last   = (cnt == CW'(NDIG - 1));
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Ripple of DIGIT full-subtractor cells over the low bits of the operand
    // shift registers. b_msb_in keeps the borrow entering the top cell of the
    // digit, which on the final digit is the borrow into the MSB.
    always_comb begin
        dig      = '0;
        bt       = b;
        b_msb_in = b;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            b_msb_in = bt;
            dig[i]   = xs[i] ^ ys[i] ^ bt;
            bt       = (~xs[i] & ys[i]) | (~(xs[i] ^ ys[i]) & bt);
        end
        b_out   = bt;
        dig_ext = WIDTH'(dig);
        // New digit enters at the MSB end; after NDIG shifts the LSB digit
        // has reached bit 0.
        rs_next = (rs >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs  <= '0;
            ys  <= '0;
            rs  <= '0;
            b   <= 1'b0;
            cnt <= '0;
            d   <= '0;
            br  <= 1'b0;
            ovf <= 1'b0;
        end else if (accept) begin
            xs  <= x;
            ys  <= y;
            b   <= bin;
            cnt <= '0;
        end else if (state == RUN) begin
            xs  <= xs >> DIGIT;
            ys  <= ys >> DIGIT;
            rs  <= rs_next;
            b   <= b_out;
            cnt <= cnt + CW'(1);
            if (last) begin
                d   <= rs_next;
                br  <= b_out;
                ovf <= b_msb_in ^ b_out;
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=8, DIGIT=1
    logic       start8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, br8, ovf8;
    logic [7:0] d8;

    // WIDTH=8, DIGIT=4
    logic       start84 = 1'b0;
    logic [7:0] x84 = '0, y84 = '0;
    logic       bin84 = 1'b0;
    logic       busy84, done84, br84, ovf84;
    logic [7:0] d84;

    // WIDTH=4, DIGIT=1,2,4 driven in parallel
    logic       start4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0;
    logic       bin4 = 1'b0;
    logic [2:0] busy4, done4, br4, ovf4;
    logic [3:0] d4 [3];

    int n_assert = 0;
    int n_fail   = 0;

    serial_sub #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .br(br8), .ovf(ovf8)
    );

    serial_sub #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .rst_n(rst_n), .start(start84), .x(x84), .y(y84), .bin(bin84),
        .busy(busy84), .done(done84), .d(d84), .br(br84), .ovf(ovf84)
    );

    for (genvar g = 0; g < 3; g++) begin : g4
        serial_sub #(.WIDTH(4), .DIGIT(1 << g)) u (
            .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4), .bin(bin4),
            .busy(busy4[g]), .done(done4[g]), .d(d4[g]), .br(br4[g]), .ovf(ovf4[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on the WIDTH=8/DIGIT=1 instance with full result and
    // timing checks. Sample index j is the negedge following edge k+j.
    task automatic op8(input string tag, input logic [7:0] xi, input logic [7:0] yi,
                       input logic bi, input logic [7:0] ed, input logic ebr,
                       input logic eovf);
        int nb, nd, at;
        logic [7:0] dd;
        logic bb, oo;
        @(negedge clk);
        x8 = xi; y8 = yi; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        nb = 0; nd = 0; at = -1; dd = '0; bb = 1'b0; oo = 1'b0;
        for (int j = 0; j <= 11; j++) begin
            if (j > 0) @(negedge clk);
            if (busy8) nb++;
            if (done8) begin
                nd++; at = j; dd = d8; bb = br8; oo = ovf8;
            end
        end
        check({tag, ".d"}, dd, ed);
        check({tag, ".br"}, bb, ebr);
        check({tag, ".ovf"}, oo, eovf);
        check({tag, ".busy_cycles"}, nb, 8);
        check({tag, ".done_count"}, nd, 1);
        check({tag, ".done_at"}, at, 8);
    endtask

    initial begin
        int nd, at;
        int tot_done [3];
        logic [7:0] cap;

        // Reset state
        #12;
        check("rst.busy8", busy8, 0);
        check("rst.done8", done8, 0);
        check("rst.d8", d8, 0);
        check("rst.br8", br8, 0);
        check("rst.ovf8", ovf8, 0);
        check("rst.busy84", busy84, 0);
        check("rst.d84", d84, 0);
        @(negedge clk);
        rst_n = 1'b1;

        op8("w8_5m3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        op8("w8_3m5", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        op8("w8_80m1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op8("w8_0m0b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

        // DIGIT=4: two-cycle op, then back-to-back start in the DONE cycle
        @(negedge clk);
        x84 = 8'hA5; y84 = 8'h5A; bin84 = 1'b0; start84 = 1'b1;
        @(negedge clk);
        start84 = 1'b0;
        check("w84.j0.busy", busy84, 1);
        check("w84.j0.done", done84, 0);
        check("w84.j0.d_held", d84, 8'h00);
        @(negedge clk);
        check("w84.j1.busy", busy84, 1);
        check("w84.j1.done", done84, 0);
        @(negedge clk);
        check("w84.j2.done", done84, 1);
        check("w84.j2.busy", busy84, 0);
        check("w84.a.d", d84, 8'h4B);
        check("w84.a.br", br84, 0);
        check("w84.a.ovf", ovf84, 1);
        x84 = 8'h10; y84 = 8'h01; start84 = 1'b1;
        @(negedge clk);
        start84 = 1'b0;
        check("w84.b.j0.busy", busy84, 1);
        check("w84.b.j0.done", done84, 0);
        @(negedge clk);
        check("w84.b.j1.d_held", d84, 8'h4B);
        check("w84.b.j1.ovf_held", ovf84, 1);
        @(negedge clk);
        check("w84.b.j2.done", done84, 1);
        check("w84.b.d", d84, 8'h0F);
        check("w84.b.br", br84, 0);
        check("w84.b.ovf", ovf84, 0);
        @(negedge clk);
        check("w84.b.done_once", done84, 0);

        // start during busy is ignored
        @(negedge clk);
        x8 = 8'h20; y8 = 8'h10; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        nd = 0; at = -1; cap = '0;
        for (int j = 0; j <= 10; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 1) begin
                x8 = 8'hFF; bin8 = 1'b1; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                nd++; at = j; cap = d8;
            end
        end
        check("ign.d", cap, 8'h10);
        check("ign.done_count", nd, 1);
        check("ign.done_at", at, 8);

        // reset in the 3rd busy cycle aborts the operation
        @(negedge clk);
        x8 = 8'h33; y8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort.busy_before", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("abort.busy", busy8, 0);
        check("abort.done", done8, 0);
        check("abort.d", d8, 0);
        check("abort.br", br8, 0);
        check("abort.ovf", ovf8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
        end
        check("abort.no_activity", nd, 0);
        op8("w8_9m4", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

        // WIDTH=4 exhaustive against an arithmetic model
        for (int k = 0; k < 3; k++) tot_done[k] = 0;
        for (int xi = 0; xi < 16; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    int sx, sy, diff, ed, ebr, eovf;
                    int dn [3];
                    int da [3];
                    logic [3:0] dc [3];
                    logic [2:0] bc, oc;
                    sx   = (xi > 7) ? xi - 16 : xi;
                    sy   = (yi > 7) ? yi - 16 : yi;
                    diff = sx - sy - bi;
                    ed   = (xi - yi - bi) & 15;
                    ebr  = (xi < yi + bi) ? 1 : 0;
                    eovf = (diff < -8 || diff > 7) ? 1 : 0;
                    bc = '0; oc = '0;
                    for (int k = 0; k < 3; k++) begin
                        dn[k] = 0; da[k] = -1; dc[k] = '0;
                    end
                    @(negedge clk);
                    x4 = 4'(xi); y4 = 4'(yi); bin4 = 1'(bi); start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    for (int j = 0; j <= 5; j++) begin
                        if (j > 0) @(negedge clk);
                        for (int k = 0; k < 3; k++) begin
                            if (done4[k]) begin
                                dn[k]++; da[k] = j;
                                dc[k] = d4[k]; bc[k] = br4[k]; oc[k] = ovf4[k];
                            end
                        end
                    end
                    for (int k = 0; k < 3; k++) begin
                        string t;
                        t = $sformatf("w4d%0d_x%0h_y%0h_b%0d", 1 << k, xi, yi, bi);
                        tot_done[k] += dn[k];
                        check({t, ".d"}, dc[k], ed);
                        check({t, ".br"}, bc[k], ebr);
                        check({t, ".ovf"}, oc[k], eovf);
                        check({t, ".done_at"}, da[k], 4 >> k);
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("w4d%0d.done_total", 1 << k), tot_done[k], 512);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Parametrised, digit-serial N-bit subtractor built from full-subtractor cells: computes d = x − y − bin.
- Processes DIGIT bits per clock, LSB first, with a registered borrow chain between digits.
- Start/busy/done handshake; result, borrow-out and signed overflow are registered and held until the next completion.
- Successor to the single-bit combinational full subtractor; serves as the shared multi-bit subtract unit for datapath blocks.

Parameters:
- WIDTH, 8: operand/result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH. DIGIT = WIDTH gives a single-cycle RUN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on a clk edge in IDLE or DONE
- x  input  WIDTH  minuend; sampled with start
- y  input  WIDTH  subtrahend; sampled with start
- bin  input  1  borrow-in; sampled with start
- busy  output  1  high while an operation is in RUN
- done  output  1  one-cycle pulse; d/br/ovf updated in the same cycle
- d  output  WIDTH  difference (registered, held)
- br  output  1  borrow out of MSB (registered, held)
- ovf  output  1  two's-complement overflow (registered, held)

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE.
  - busy, done, d, br, ovf = 0.
  - Internal shift registers, borrow register and digit counter = 0.
  - Reset asserted mid-operation aborts it; no done is produced.
- Bit cell for each bit i, with b the incoming borrow:
  - d_i = x_i ^ y_i ^ b
  - b_out = (~x_i & y_i) | (~(x_i ^ y_i) & b)
  - Within a digit, DIGIT cells chain combinationally; the final b_out is registered for the next digit.
- States:
  - IDLE: start=1 → latch x, y; borrow register ← bin; counter ← 0; go to RUN; busy=1 from the next cycle.
  - RUN: each cycle, process the low DIGIT bits of the operand shift registers, then shift the operands right by DIGIT. Result bits shift in from the MSB end of the result shift register; counter increments.
    - On the cycle where counter = WIDTH/DIGIT − 1:
      - Write the completed result into d.
      - br ← final borrow.
      - ovf ← (borrow into MSB cell) XOR (borrow out of MSB cell).
      - Go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle.
    - start=1 in DONE is accepted as in IDLE (back-to-back operation, no bubble).
    - Otherwise go to IDLE.
- Latency: if start is sampled at edge k, done is high in the cycle after edge k + WIDTH/DIGIT, and busy is high for exactly WIDTH/DIGIT cycles.
- start while busy=1 is ignored; no queuing, and the x/y/bin changes are not seen.
- d/br/ovf change only at completion; they keep the previous result during RUN.
- All arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, DIGIT=1, x=0x05, y=0x03, bin=0 → d=0x02, br=0, ovf=0. busy high for 8 cycles; done pulses exactly once, 8 cycles after start.
- WIDTH=8, DIGIT=1:
  - x=0x03, y=0x05, bin=0 → d=0xFE, br=1, ovf=0.
  - x=0x80, y=0x01, bin=0 → d=0x7F, br=0, ovf=1.
  - x=0x00, y=0x00, bin=1 → d=0xFF, br=1, ovf=0.
- WIDTH=8, DIGIT=4, x=0xA5, y=0x5A, bin=0 → d=0x4B, br=0, ovf=1; done 2 cycles after start. Assert start again in the DONE cycle with x=0x10, y=0x01 → next done gives d=0x0F, br=0, ovf=0.
- Start x=0x20, y=0x10. At the 2nd busy cycle, pulse start with x=0xFF → ignored; d=0x10 at done. Then start a new op, and pull rst_n low at its 3rd busy cycle → busy, done, d, br and ovf all 0 immediately, and no done pulse. Release reset, run x=0x09, y=0x04 → d=0x05.
- WIDTH=4 with DIGIT=1, 2 and 4: exhaustive x, y ∈ 0..15, bin ∈ {0,1}. Compare against the reference model: d = (x−y−bin) mod 16, br = (x < y+bin), ovf = signed-range violation. Check zero mismatches and the correct done count.
